// File: rtl/max_uint16_serial_if.sv
// ---------------------------------------------------------------------------
// max_uint16_serial_if
// Handshake bundle for the bit-serial unsigned max unit.
//   in_valid / in_ready  : operand-pair handshake (producer -> unit)
//   A, B                 : unsigned operands, sampled on the accepting edge
//   out_valid / out_ready: result handshake (unit -> consumer)
//   Y                    : max(A, B)
//   a_gt                 : 1 iff A > B (0 on a tie)
// master = producer/consumer side, slave = the max unit itself.
// ---------------------------------------------------------------------------
interface max_uint16_serial_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Y;
  logic             a_gt;

  modport master (
    output in_valid, A, B, out_ready,
    input  in_ready, out_valid, Y, a_gt
  );

  modport slave (
    input  in_valid, A, B, out_ready,
    output in_ready, out_valid, Y, a_gt
  );
endinterface

// File: rtl/max_uint16_serial.sv
// ---------------------------------------------------------------------------
// max_uint16_serial
// Bit-serial unsigned max: accepts (A, B), scans MSB-first one bit per clock
// and returns Y = max(A, B) plus a_gt = (A > B).
// Ports:
//   clk  : single clock, rising edge
//   rst  : asynchronous, active-high reset
//   bus  : max_uint16_serial_if.slave (in/out valid-ready handshakes, A, B,
//          Y, a_gt)
// Latency: out_valid rises WIDTH edges after the accepting edge.
// ---------------------------------------------------------------------------
module max_uint16_serial #(
  parameter int WIDTH = 16
) (
  input logic                clk,
  input logic                rst,
  max_uint16_serial_if.slave bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             gt_a_q, gt_a_d;
  logic             gt_b_q, gt_b_d;
  logic             a_gt_q, a_gt_d;

  // Operands are shifted left each RUN cycle, so the bit under test is
  // always in the MSB position.
  logic a_bit, b_bit;
  assign a_bit = a_q[WIDTH-1];
  assign b_bit = b_q[WIDTH-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    y_d     = y_q;
    gt_a_d  = gt_a_q;
    gt_b_d  = gt_b_q;
    a_gt_d  = a_gt_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d = RUN;
          a_d     = bus.A;
          b_d     = bus.B;
          gt_a_d  = 1'b0;
          gt_b_d  = 1'b0;
          cnt_d   = CW'(WIDTH - 1);
        end
      end

      RUN: begin
        // First differing bit decides; afterwards both flags are frozen.
        if (!gt_a_q && !gt_b_q && (a_bit != b_bit)) begin
          gt_a_d = a_bit;
          gt_b_d = ~a_bit;
        end
        // Uses the updated flag so the deciding bit already comes from B.
        y_d   = {y_q[WIDTH-2:0], (gt_b_d ? b_bit : a_bit)};
        a_d   = a_q << 1;
        b_d   = b_q << 1;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          state_d = DONE;
          a_gt_d  = gt_a_d;
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      y_q     <= '0;
      gt_a_q  <= 1'b0;
      gt_b_q  <= 1'b0;
      a_gt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      y_q     <= y_d;
      gt_a_q  <= gt_a_d;
      gt_b_q  <= gt_b_d;
      a_gt_q  <= a_gt_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.Y         = y_q;
  assign bus.a_gt      = a_gt_q;

endmodule

// File: tb/tb_max_uint16_serial.sv
// ---------------------------------------------------------------------------
// tb_max_uint16_serial
// Self-checking bench for max_uint16_serial. Expected results come from plain
// arithmetic (max via '>') and an in-order queue of issued pairs.
// ---------------------------------------------------------------------------
module tb_max_uint16_serial;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  max_uint16_serial_if #(.WIDTH(16)) bus ();

  max_uint16_serial #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Present one pair, wait for acceptance, then wait (bounded) for out_valid.
  // Returns at #1 after the edge on which out_valid was first seen.
  task automatic run_pair(input logic [15:0] a, input logic [15:0] b,
                          output logic [15:0] y, output logic g, output int lat);
    bus.in_valid = 1'b1;
    bus.A        = a;
    bus.B        = b;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.A        = 16'($urandom);
    bus.B        = 16'($urandom);
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    y = bus.Y;
    g = bus.a_gt;
  endtask

  task automatic test_reset;
    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    #1 rst = 1'b1;
    #1;
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.Y !== 16'h0 || bus.a_gt !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: out_valid=%b in_ready=%b Y=%h a_gt=%b, required 0 1 0000 0",
               bus.out_valid, bus.in_ready, bus.Y, bus.a_gt);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release_in_ready: got %b, required 1", bus.in_ready);
    end
  endtask

  task automatic test_directed;
    logic [15:0] va [5] = '{16'h1234, 16'h00FF, 16'hA5A5, 16'hFFFF, 16'h0000};
    logic [15:0] vb [5] = '{16'h1233, 16'h8000, 16'hA5A5, 16'h0000, 16'h0000};
    logic [15:0] y, exp_y;
    logic        g, exp_g;
    int          lat;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      exp_y = (va[i] > vb[i]) ? va[i] : vb[i];
      exp_g = (va[i] > vb[i]);
      run_pair(va[i], vb[i], y, g, lat);
      $display("txn directed a=%h b=%h y=%h a_gt=%b latency=%0d", va[i], vb[i], y, g, lat);
      total++;
      if (lat !== 16) begin
        bad++;
        $display("FAIL directed_latency[%0d]: got %0d edges, required 16", i, lat);
      end
      total++;
      if (y !== exp_y) begin
        bad++;
        $display("FAIL directed_y[%0d]: got %h, required %h", i, y, exp_y);
      end
      total++;
      if (g !== exp_g) begin
        bad++;
        $display("FAIL directed_a_gt[%0d]: got %b, required %b", i, g, exp_g);
      end
      @(posedge clk); #1;
      total++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        bad++;
        $display("FAIL directed_one_cycle_valid[%0d]: out_valid=%b in_ready=%b, required 0 1",
                 i, bus.out_valid, bus.in_ready);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [15:0] a, b, y, exp_y;
    logic        g, exp_g;
    int          lat;
    a = 16'($urandom);
    b = 16'($urandom);
    exp_y = (a > b) ? a : b;
    exp_g = (a > b);
    bus.out_ready = 1'b0;
    run_pair(a, b, y, g, lat);
    $display("txn backpressure a=%h b=%h y=%h a_gt=%b latency=%0d", a, b, y, g, lat);
    total++;
    if (y !== exp_y || g !== exp_g) begin
      bad++;
      $display("FAIL bp_result: got Y=%h a_gt=%b, required Y=%h a_gt=%b", y, g, exp_y, exp_g);
    end
    for (int c = 0; c < 10; c++) begin
      bus.in_valid = 1'($urandom_range(1));
      bus.A        = 16'($urandom);
      bus.B        = 16'($urandom);
      @(posedge clk); #1;
      total++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.Y !== exp_y || bus.a_gt !== exp_g) begin
        bad++;
        $display("FAIL bp_hold[%0d]: out_valid=%b in_ready=%b Y=%h a_gt=%b, required 1 0 %h %b",
                 c, bus.out_valid, bus.in_ready, bus.Y, bus.a_gt, exp_y, exp_g);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b, required 0 1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset_mid_run;
    logic [15:0] y;
    logic        g;
    int          lat;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.A         = 16'hFFFF;
    bus.B         = 16'h0001;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    // Eight more edges: bits 15..8 done, bit 7 is the one in progress.
    repeat (8) @(posedge clk);
    #1;
    total++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL midrst_running: in_ready=%b out_valid=%b, required 0 0", bus.in_ready, bus.out_valid);
    end
    #1 rst = 1'b1;
    #1;
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.Y !== 16'h0 || bus.a_gt !== 1'b0) begin
      bad++;
      $display("FAIL midrst_outputs: out_valid=%b in_ready=%b Y=%h a_gt=%b, required 0 1 0000 0",
               bus.out_valid, bus.in_ready, bus.Y, bus.a_gt);
    end
    #1 rst = 1'b0;
    run_pair(16'd3, 16'd5, y, g, lat);
    $display("txn after_reset a=0003 b=0005 y=%h a_gt=%b latency=%0d", y, g, lat);
    total++;
    if (lat !== 16 || y !== 16'd5 || g !== 1'b0) begin
      bad++;
      $display("FAIL midrst_fresh_pair: latency=%0d Y=%h a_gt=%b, required 16 0005 0", lat, y, g);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    logic [16:0] exp_q [$];
    logic [16:0] e;
    logic [15:0] pa, pb, ys;
    logic        pend, acc, hs, gs;
    int          issued, received, cycles;
    pend = 1'b0; issued = 0; received = 0; cycles = 0;
    pa = '0; pb = '0;
    while ((issued < 1000 || received < 1000) && cycles < 60000) begin
      if (!pend && issued < 1000 && $urandom_range(3) != 0) begin
        pend = 1'b1;
        pa   = 16'($urandom);
        pb   = 16'($urandom);
      end
      bus.in_valid  = pend;
      bus.A         = pend ? pa : 16'($urandom);
      bus.B         = pend ? pb : 16'($urandom);
      bus.out_ready = 1'($urandom_range(1));
      acc = bus.in_valid && bus.in_ready;
      hs  = bus.out_valid && bus.out_ready;
      ys  = bus.Y;
      gs  = bus.a_gt;
      @(posedge clk); #1;
      cycles++;
      if (acc) begin
        exp_q.push_back({((pa > pb) ? pa : pb), (pa > pb)});
        pend = 1'b0;
        issued++;
      end
      if (hs) begin
        received++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL rand_unexpected_result: got Y=%h a_gt=%b, required no result", ys, gs);
        end else begin
          e = exp_q.pop_front();
          $display("txn random #%0d y=%h a_gt=%b expected y=%h a_gt=%b", received, ys, gs, e[16:1], e[0]);
          if (ys !== e[16:1] || gs !== e[0]) begin
            bad++;
            $display("FAIL rand_result[%0d]: got Y=%h a_gt=%b, required Y=%h a_gt=%b",
                     received, ys, gs, e[16:1], e[0]);
          end
        end
      end
    end
    total++;
    if (issued != 1000 || received != 1000 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL rand_counts: issued=%0d received=%0d pending=%0d, required 1000 1000 0",
               issued, received, exp_q.size());
    end
    bus.in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
